decoder_4to16: RTL and testbench



---
 rtl/decoder_4to16.sv | 44 ++++
 tb/tb_decoder_4to16.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/decoder_4to16.sv
// Binary-to-one-hot decoder with active-high enable; combinational by default.
// Define DECODER_REG_OUT_EN to register decoder_out on clk with synchronous rst.
module decoder_4to16 #(
  parameter  int unsigned IN_WIDTH  = 4,
  localparam int unsigned OUT_WIDTH = 1 << IN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  binary_in,
  input  logic                 enable,
  output logic [OUT_WIDTH-1:0] decoder_out
);

  logic [OUT_WIDTH-1:0] dec_d;

  always_comb begin
    dec_d = '0;
    if (enable) begin
      dec_d[binary_in] = 1'b1;
    end
  end

`ifdef DECODER_REG_OUT_EN
  logic [OUT_WIDTH-1:0] dec_q;

  // Reset wins over any decode in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q <= '0;
    end else begin
      dec_q <= dec_d;
    end
  end

  assign decoder_out = dec_q;
`else
  // clk/rst stay on the port list so both builds share one interface.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst};

  assign decoder_out = dec_d;
`endif

endmodule

// File: tb/tb_decoder_4to16.sv
// Directed self-checking bench for decoder_4to16; covers both the combinational
// build and, when DECODER_REG_OUT_EN is defined, the registered build.
module tb_decoder_4to16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  binary_in;
  logic        enable;
  logic [15:0] decoder_out;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  decoder_4to16 #(.IN_WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .binary_in   (binary_in),
    .enable      (enable),
    .decoder_out (decoder_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] exp);
    n_cmp++;
    assert (decoder_out === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, decoder_out, exp);
    end
  endtask

  // Drive a vector and wait until it is visible at the output.
  task automatic apply(input logic en, input logic [3:0] code);
`ifdef DECODER_REG_OUT_EN
    @(negedge clk);
    enable    = en;
    binary_in = code;
    @(posedge clk);
    #1;
`else
    enable    = en;
    binary_in = code;
    #10;
`endif
  endtask

  initial begin
    logic [15:0] exp;

    rst       = 1'b1;
    enable    = 1'b0;
    binary_in = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    apply(1'b0, 4'hF);
    check("disabled_f", 16'h0000);
    apply(1'b1, 4'h1);
    check("code1", 16'h0002);
    apply(1'b1, 4'h0);
    check("code0", 16'h0001);

    for (int i = 1; i < 16; i++) begin
      apply(1'b1, 4'(i));
      exp = 16'h0001 << i;
      check($sformatf("sweep_%0d", i), exp);
      if (n_mis != 0) begin
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $fatal(1, "FAIL sweep_abort: sweep stopped at code %0d", i);
      end
    end
    check("sweep_end", 16'h8000);

    apply(1'b1, 4'h5);
    check("en_hold5", 16'h0020);
    apply(1'b0, 4'h5);
    check("en_drop5", 16'h0000);
    apply(1'b1, 4'hA);
    check("codeA", 16'h0400);

`ifdef DECODER_REG_OUT_EN
    // Reset held two cycles with live inputs, then one-edge latency on release.
    @(negedge clk);
    rst       = 1'b1;
    enable    = 1'b1;
    binary_in = 4'h3;
    @(posedge clk); #1;
    check("rst_cyc1", 16'h0000);
    @(posedge clk); #1;
    check("rst_cyc2", 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    check("rst_release_hold", 16'h0000);
    @(posedge clk); #1;
    check("post_rst_code3", 16'h0008);

    @(negedge clk);
    binary_in = 4'h7;
    #1;
    check("latency_before", 16'h0008);
    @(posedge clk); #1;
    check("latency_after", 16'h0080);

    apply(1'b1, 4'hE);
    check("codeE", 16'h4000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst", 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_recover", 16'h4000);

    @(negedge clk);
    enable = 1'b0;
    #1;
    check("en_fall_before", 16'h4000);
    @(posedge clk); #1;
    check("en_fall_after", 16'h0000);
`else
    apply(1'b1, 4'h9);
    check("code9", 16'h0200);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_effect", 16'h0200);
    rst = 1'b0;
    enable = 1'b0;
    #10;
    check("en_immediate_off", 16'h0000);
    binary_in = 4'hC;
    enable    = 1'b1;
    #10;
    check("codeC", 16'h1000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
